// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: streaming front/back end for a fixed-latency sorter network.
// Handshake rule (both ports): a beat transfers on a rising edge where valid
// and ready are both high; once out_valid is high, out_data/out_last hold
// until that transfer happens.
// Input side collects a batch (1..SIZE elements) into ibuf, which drives the
// sorter. Output side streams the captured, sorted vector back out. The two
// sides own separate buffers, so the next batch fills while the current one drains.
module sort_stream_ctrl #(
  parameter int VALUE_BITS   = 8,
  parameter int DEPTH        = 4,
  parameter int SORT_LATENCY = 1,
  parameter int SIZE         = 1 << DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [VALUE_BITS-1:0]      in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VALUE_BITS-1:0]      out_data,
  output logic                       out_last,
  output logic [SIZE*VALUE_BITS-1:0] sort_in,
  input  logic [SIZE*VALUE_BITS-1:0] sort_out,
  output logic                       busy
);

  localparam int CW = DEPTH + 1;
  localparam int LW = (SORT_LATENCY < 1) ? 1 : $clog2(SORT_LATENCY + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(SORT_LATENCY);

  typedef enum logic {FILL, WAIT} in_state_t;
  typedef enum logic {IDLE, DRAIN} out_state_t;

  in_state_t             in_st_q;
  out_state_t            out_st_q;
  logic                  in_ready_q;
  logic [CW-1:0]         wcnt_q;
  logic [CW-1:0]         n_q;
  logic [LW-1:0]         lat_q;
  logic [CW-1:0]         rcnt_q;
  logic [CW-1:0]         out_n_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [VALUE_BITS-1:0] out_data_q;
  logic [VALUE_BITS-1:0] ibuf_q [SIZE];
  logic [VALUE_BITS-1:0] obuf_q [SIZE];

  logic          in_hs;
  logic          out_hs;
  logic          batch_end;
  logic          capture;
  logic [CW-1:0] rnext;

  // Transfer and capture decisions shared by both FSMs
  always_comb begin
    in_hs     = in_valid & in_ready_q;
    out_hs    = out_valid_q & out_ready;
    batch_end = in_hs & (in_last | (wcnt_q == LAST_IDX));
    // Capture once the sorter has settled and the output side is free, or is
    // releasing its final beat on this very edge (gives back-to-back drains).
    capture   = (in_st_q == WAIT) && (lat_q == '0) &&
                ((out_st_q == IDLE) || (out_hs && out_last_q));
    rnext     = rcnt_q + CW'(1);
  end

  // Input buffer is presented to the sorter untouched; element i at slice i
  for (genvar g = 0; g < SIZE; g++) begin : g_sort_in
    assign sort_in[g*VALUE_BITS +: VALUE_BITS] = ibuf_q[g];
  end

  // Input FSM: fill ibuf, then hold it steady while the sorter works
  always_ff @(posedge clk) begin
    if (rst) begin
      in_st_q    <= FILL;
      in_ready_q <= 1'b0;
      wcnt_q     <= '0;
      n_q        <= '0;
      lat_q      <= '0;
      for (int i = 0; i < SIZE; i++) ibuf_q[i] <= '1;
    end else begin
      case (in_st_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (in_hs) begin
            ibuf_q[wcnt_q[DEPTH-1:0]] <= in_data;
            wcnt_q <= wcnt_q + CW'(1);
            if (batch_end) begin
              n_q        <= wcnt_q + CW'(1);
              lat_q      <= LAT_INIT;
              in_st_q    <= WAIT;
              in_ready_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          in_ready_q <= 1'b0;
          if (lat_q != '0) lat_q <= lat_q - LW'(1);
          if (capture) begin
            // Re-pad with max value so short batches sort pads to the top
            for (int i = 0; i < SIZE; i++) ibuf_q[i] <= '1;
            wcnt_q     <= '0;
            in_st_q    <= FILL;
            in_ready_q <= 1'b1;
          end
        end
        default: in_st_q <= FILL;
      endcase
    end
  end

  // Output buffer takes the sorted vector on the capture edge
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < SIZE; i++) obuf_q[i] <= sort_out[i*VALUE_BITS +: VALUE_BITS];
    end
  end

  // Output FSM: stream exactly out_n sorted elements, pads are never reached
  always_ff @(posedge clk) begin
    if (rst) begin
      out_st_q    <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      rcnt_q      <= '0;
      out_n_q     <= '0;
    end else if (capture) begin
      out_st_q    <= DRAIN;
      out_valid_q <= 1'b1;
      rcnt_q      <= '0;
      out_n_q     <= n_q;
      out_data_q  <= sort_out[VALUE_BITS-1:0];
      out_last_q  <= (n_q == CW'(1));
    end else if (out_hs) begin
      if (out_last_q) begin
        out_st_q    <= IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        rcnt_q     <= rnext;
        out_data_q <= obuf_q[rnext[DEPTH-1:0]];
        out_last_q <= (rnext == out_n_q - CW'(1));
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (in_st_q == WAIT) | (out_st_q == DRAIN);

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: two instances (DEPTH=4/LAT=1 and DEPTH=5/LAT=4),
// each attached to a behavioural sorter; a queue-sorted scoreboard checks output.
module tb_sort_stream_ctrl;

  localparam int VB = 8;
  localparam int SA = 16;
  localparam int SB = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- shared drive, muxed per instance ----------------
  logic          sel;
  logic          in_valid, in_last, out_ready;
  logic [VB-1:0] in_data;
  logic          in_ready, out_valid, out_last, busy;
  logic [VB-1:0] out_data;

  logic             in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a;
  logic [VB-1:0]    out_data_a;
  logic [SA*VB-1:0] sort_in_a, sort_out_a;
  logic             in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b;
  logic [VB-1:0]    out_data_b;
  logic [SB*VB-1:0] sort_in_b, sort_out_b;

  assign in_valid_a  = in_valid & ~sel;
  assign in_valid_b  = in_valid & sel;
  assign out_ready_a = out_ready & ~sel;
  assign out_ready_b = out_ready & sel;
  assign in_ready  = sel ? in_ready_b  : in_ready_a;
  assign out_valid = sel ? out_valid_b : out_valid_a;
  assign out_last  = sel ? out_last_b  : out_last_a;
  assign out_data  = sel ? out_data_b  : out_data_a;
  assign busy      = sel ? busy_b      : busy_a;

  sort_stream_ctrl #(.VALUE_BITS(VB), .DEPTH(4), .SORT_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a),
    .sort_in(sort_in_a), .sort_out(sort_out_a), .busy(busy_a)
  );

  sort_stream_ctrl #(.VALUE_BITS(VB), .DEPTH(5), .SORT_LATENCY(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b),
    .sort_in(sort_in_b), .sort_out(sort_out_b), .busy(busy_b)
  );

  // ---------------- behavioural sorters ----------------
  function automatic logic [SB*VB-1:0] sort_vec(input logic [SB*VB-1:0] v, input int n);
    logic [VB-1:0] a [SB];
    logic [VB-1:0] t;
    logic [SB*VB-1:0] r;
    for (int i = 0; i < SB; i++) a[i] = v[i*VB +: VB];
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    r = '0;
    for (int i = 0; i < n; i++) r[i*VB +: VB] = a[i];
    return r;
  endfunction

  logic [SB*VB-1:0] sorted_a_full, sorted_b_full;
  logic [SA*VB-1:0] sa_q;
  logic [SB*VB-1:0] sb_q [4];
  assign sorted_a_full = sort_vec({{(SB-SA)*VB{1'b0}}, sort_in_a}, SA);
  assign sorted_b_full = sort_vec(sort_in_b, SB);
  assign sort_out_a = sa_q;
  assign sort_out_b = sb_q[3];

  always @(posedge clk) begin
    sa_q <= sorted_a_full[SA*VB-1:0];
    sb_q[0] <= sorted_b_full;
    for (int i = 1; i < 4; i++) sb_q[i] <= sb_q[i-1];
  end

  // ---------------- scoreboard state ----------------
  logic [8:0]    exp_q[$];   // {last, data}
  logic [9:0]    src_q[$];   // {end_of_batch, in_last, data}
  logic [VB-1:0] bq[$];
  int  vectors = 0, miscompares = 0;
  int  cyc = 0, last_hs_cyc = 0, first_valid_cyc = -1, beats = 0;
  int  rdy_mode = 0, in_gap = 0;
  bit  gap_chk = 0, prev_stall = 0, prev_last_hs = 0, hold = 0;
  logic [8:0] prev_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_batch(input bit set_last);
    logic [VB-1:0] s[$];
    int n;
    n = bq.size();
    for (int i = 0; i < n; i++)
      src_q.push_back({(i == n-1), (i == n-1) & set_last, bq[i]});
    s = bq;
    s.sort();
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n-1), s[i]});
  endtask

  // ---------------- driver / monitor, one cycle ----------------
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      check("hold_valid", {31'b0, out_valid}, 1);
      check("hold_data", {23'b0, out_last, out_data}, {23'b0, prev_out});
    end
    if (gap_chk && prev_last_hs && exp_q.size() > 0) check("no_gap", {31'b0, out_valid}, 1);
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    in_valid = (src_q.size() > 0) && (hold || ($urandom_range(0, 99) >= in_gap));
    if (src_q.size() > 0) begin
      in_data = src_q[0][7:0];
      in_last = src_q[0][8];
    end else begin
      in_data = 8'($urandom);
      in_last = 1'b0;
    end
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    hold = in_valid && !in_ready;
    if (in_valid && in_ready) begin
      if (src_q[0][9]) last_hs_cyc = cyc;
      void'(src_q.pop_front());
    end
    prev_last_hs = 1'b0;
    if (out_valid && out_ready) begin
      check("beat_expected", {31'b0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat", {23'b0, out_last, out_data}, {23'b0, e});
      end
      prev_last_hs = out_last;
      beats++;
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_last, out_data};
  endtask

  task automatic run_drain(input int max, input string tag);
    int k;
    k = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && k < max) begin
      step();
      k++;
    end
    check(tag, src_q.size() + exp_q.size(), 0);
    repeat (3) step();
    check({tag, "_idle_valid"}, {31'b0, out_valid}, 0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 0);
    check({tag, "_idle_ready"}, {31'b0, in_ready}, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    hold = 0; prev_stall = 0; prev_last_hs = 0;
    src_q.delete(); exp_q.delete();
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    check("rst_out_data", {24'b0, out_data}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Full batch 15..0, out_ready=1, latency check
    rdy_mode = 0; in_gap = 0; first_valid_cyc = -1;
    bq.delete();
    for (int i = 0; i < SA; i++) bq.push_back(8'(15 - i));
    push_batch(1'b0);
    run_drain(200, "full_desc");
    check("lat_a", first_valid_cyc - last_hs_cyc, 3);

    // Short batches, no pads emitted
    bq.delete(); bq.push_back(8'd9); bq.push_back(8'd3); bq.push_back(8'd7);
    push_batch(1'b1);
    run_drain(200, "short_937");
    bq.delete(); bq.push_back(8'd255); bq.push_back(8'd0);
    push_batch(1'b1);
    run_drain(200, "short_ff00");

    // Back-to-back: B parks in WAIT while A is stalled
    rdy_mode = 2;
    for (int b = 0; b < 2; b++) begin
      bq.delete();
      for (int i = 0; i < SA; i++) bq.push_back(8'($urandom));
      push_batch(1'b0);
    end
    k = 0;
    while (src_q.size() > 0 && k < 200) begin step(); k++; end
    repeat (10) step();
    check("b2b_filled", src_q.size(), 0);
    check("b2b_in_ready", {31'b0, in_ready}, 0);
    check("b2b_busy", {31'b0, busy}, 1);
    check("b2b_out_valid", {31'b0, out_valid}, 1);
    rdy_mode = 0; gap_chk = 1;
    run_drain(400, "b2b");
    gap_chk = 0;

    // Random backpressure and input gaps, random batch lengths
    rdy_mode = 1; in_gap = 30;
    for (int b = 0; b < 6; b++) begin
      int len;
      len = $urandom_range(1, SA);
      bq.delete();
      for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
      push_batch((len < SA) || ($urandom_range(0, 1) == 1));
    end
    run_drain(3000, "bp_rand");
    rdy_mode = 0; in_gap = 0;

    // Reset mid-DRAIN after 5 beats
    bq.delete();
    for (int i = 0; i < SA; i++) bq.push_back(8'($urandom));
    push_batch(1'b0);
    beats = 0; k = 0;
    while (beats < 5 && k < 200) begin step(); k++; end
    check("mid_drain_beats", beats, 5);
    do_reset();
    bq.delete(); bq.push_back(8'd2); bq.push_back(8'd1);
    push_batch(1'b1);
    run_drain(200, "after_drain_rst");

    // Reset mid-FILL after 5 inputs
    bq.delete();
    for (int i = 0; i < SA; i++) bq.push_back(8'($urandom));
    push_batch(1'b0);
    k = 0;
    while (src_q.size() > SA - 5 && k < 200) begin step(); k++; end
    do_reset();
    bq.delete(); bq.push_back(8'd1); bq.push_back(8'd2);
    push_batch(1'b1);
    run_drain(200, "after_fill_rst");

    // DEPTH=5, SORT_LATENCY=4 instance: 32 descending inputs
    sel = 1'b1;
    do_reset();
    first_valid_cyc = -1;
    bq.delete();
    for (int i = 0; i < SB; i++) bq.push_back(8'(250 - 3*i));
    push_batch(1'b0);
    run_drain(400, "b_desc32");
    check("lat_b", first_valid_cyc - last_hs_cyc, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
- Streaming controller that sequences one instance of the team's `sorter` network.
- Collects up to SIZE values from a valid/ready input stream and presents them in parallel to the sorter.
- Waits the sorter's fixed pipeline latency, captures the sorted vector and streams the real elements back out in ascending order.
- Input and output buffers are separate: batch k+1 fills while batch k drains.

Parameters:
- VALUE_BITS, 8, width of one element.
- DEPTH, 4, log2 of batch size; must match the attached sorter.
- SORT_LATENCY, 1, clock edges from sort_in stable to sort_out valid; >=1.
- SIZE, 1<<DEPTH, derived; do not override.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts input element.
- in_data  in  VALUE_BITS  input element.
- in_last  in  1  final element of batch (may be short).
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts output element.
- out_data  out  VALUE_BITS  sorted element.
- out_last  out  1  final real element of batch.
- sort_in  out  SIZE*VALUE_BITS  packed vector to sorter .in, element i at [i].
- sort_out  in  SIZE*VALUE_BITS  packed vector from sorter .out (DIRECTION=0, ascending).
- busy  out  1  any batch in WAIT or DRAIN.

Behaviour:
- Reset: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0. Input buffer preset to all-ones, counters=0, input FSM=FILL, output FSM=IDLE. in_ready=1 on the first cycle after rst deasserts. rst asserted mid-batch discards all buffered and in-flight data.
- Input FSM:
  - FILL:
    - in_ready=1.
    - Each handshake writes in_data to ibuf[wcnt], wcnt++.
    - On a handshake with in_last=1 or wcnt==SIZE-1: latch n=wcnt+1 (1..SIZE) and go to WAIT with lat_cnt=SORT_LATENCY.
    - Unwritten slots keep the all-ones pad.
  - WAIT:
    - in_ready=0; ibuf held constant, so sort_in is stable.
    - lat_cnt decrements each cycle to 0.
    - Capture when lat_cnt==0 and output FSM is IDLE, or is in DRAIN with the final beat handshaking that same cycle. On the capture edge: obuf<=sort_out, rcnt<=0, out_n<=n, ibuf<=all-ones, wcnt<=0, input FSM->FILL.
    - If lat_cnt==0 but the output is busy, stay in WAIT; sort_out remains valid because ibuf is held.
- Output FSM:
  - IDLE: out_valid=0. Enters DRAIN on the capture edge.
  - DRAIN:
    - out_valid=1, out_data=obuf[rcnt], out_last=(rcnt==out_n-1).
    - Handshake (out_valid & out_ready) increments rcnt.
    - Handshake on out_last goes to IDLE, or stays in DRAIN with the new batch if capture occurs on the same edge.
    - out_data/out_last are stable while out_valid=1 and out_ready=0.
- Padding: pads are max value, so they sort to indices >= n and are never emitted. Real all-ones elements are indistinguishable from pads but are emitted correctly, because exactly n elements leave.
- Latency:
  - Last input handshake at edge t → capture at edge t+SORT_LATENCY+1 when the output is idle.
  - First out_valid is seen the cycle after capture.
  - in_ready re-asserts the cycle after capture.
- in_last is ignored when wcnt==SIZE-1; the batch ends regardless.
- busy = (input FSM==WAIT) | (output FSM==DRAIN).
- Counters wcnt, rcnt are DEPTH+1 bits wide; no wrap is permitted.

Test Plan:
- Reset, then one full batch of 16 with in_data=15..0 and out_ready=1: outputs 0..15, out_last on the 16th beat, first out_valid 3 cycles after the last input handshake (SORT_LATENCY=1).
- Short batch {9,3,7} with in_last on 7: exactly 3 beats 3,7,9, out_last on 9, no pad emitted; repeat with {255,0} → 0,255.
- Back-to-back: batch A (16 random) fills, batch B (16 random) fills while out_ready=0. B waits in WAIT with in_ready=0 until A's last beat. Then B's capture occurs on that edge, with no gap beat.
- Backpressure: toggle out_ready randomly. out_data holds while out_valid & !out_ready, and the sequence matches a reference sort.
- rst asserted mid-DRAIN (after 5 of 16 beats) and mid-FILL: the next cycle has out_valid=0 and in_ready=0. The following batch {1,2} sorts correctly with no stale data.
- SORT_LATENCY=4 with DEPTH=5: the capture edge is exactly 5 edges after the last input handshake, and 32 descending inputs emerge ascending.
